// File: rtl/gpio_bidir_port.sv
// gpio_bidir_port
//   Register-mapped controller for a bidirectional GPIO header. User logic
//   writes and reads eight registers through a simple strobe interface. Each
//   header pin can be an output (driven from out_reg) or an input (high-Z).
//   Every pin value is resynchronised into the clock domain, and per-pin
//   rising and falling edges are captured into sticky bits that drive a
//   level interrupt.
//
// Parameters
//   WIDTH        number of pins handled; every per-pin register is WIDTH bits
//   SYNC_STAGES  flops in the input synchronizer chain (2 or 3)
//
// Ports
//   CLOCK_50  in     system clock; all state changes on its rising edge
//   Reset     in     asynchronous, active-high reset
//   addr      in     register select (0 DATA, 1 DIR, 2 SET, 3 CLR,
//                    4 RISE_EN, 5 FALL_EN, 6 EDGE_CAP, 7 IRQ_EN)
//   wr        in     write strobe, one access per cycle it is high
//   rd        in     read strobe
//   wdata     in     write data
//   rdata     out    registered read data; holds its value while rd is low
//   irq       out    high while any enabled, captured edge is pending
//   GPIO      inout  header pins; driven where DIR is 1, otherwise high-Z
module gpio_bidir_port #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [2:0]       addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] GPIO
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_SET      = 3'd2;
  localparam logic [2:0] ADDR_CLR      = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd6;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd7;

  logic [WIDTH-1:0] out_reg,      out_next;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] rise_en_reg;
  logic [WIDTH-1:0] fall_en_reg;
  logic [WIDTH-1:0] irq_en_reg;
  logic [WIDTH-1:0] edge_cap_reg, edge_cap_next;
  logic [WIDTH-1:0] pin_prev_reg;
  logic [WIDTH-1:0] rdata_reg,    rdata_next;
  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];

  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;

  // ---------------------------------------------------------------------
  // Pin drivers: each pin is driven straight from the registers, so a new
  // DIR or out_reg value appears on the header at the edge that wrote it.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin_drive
      assign GPIO[gi] = dir_reg[gi] ? out_reg[gi] : 1'bz;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Input synchronizer. Stage 0 samples the raw pins; the last stage is
  // the synchronized value pin_s. Output pins are sampled as well, which
  // gives loopback on DATA reads.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= GPIO;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign pin_s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Edge detection and capture. The set term is OR-ed in after the W1C
  // clear, so an edge arriving in the same cycle as its clear survives.
  // ---------------------------------------------------------------------
  assign rise     = pin_s & ~pin_prev_reg;
  assign fall     = ~pin_s & pin_prev_reg;
  assign edge_set = (rise & rise_en_reg) | (fall & fall_en_reg);
  assign edge_clr = (wr && addr == ADDR_EDGE_CAP) ? wdata : '0;

  always_comb begin
    edge_cap_next = (edge_cap_reg & ~edge_clr) | edge_set;
  end

  // Output register updates: plain load, atomic set and atomic clear.
  always_comb begin
    out_next = out_reg;
    if (wr) begin
      case (addr)
        ADDR_DATA: out_next = wdata;
        ADDR_SET:  out_next = out_reg | wdata;
        ADDR_CLR:  out_next = out_reg & ~wdata;
        default:   out_next = out_reg;
      endcase
    end
  end

  // Read mux works on current register values, so a read that coincides
  // with a write to the same address returns the pre-write contents.
  always_comb begin
    rdata_next = rdata_reg;
    if (rd) begin
      case (addr)
        ADDR_DATA:     rdata_next = pin_s;
        ADDR_DIR:      rdata_next = dir_reg;
        ADDR_SET:      rdata_next = out_reg;
        ADDR_CLR:      rdata_next = out_reg;
        ADDR_RISE_EN:  rdata_next = rise_en_reg;
        ADDR_FALL_EN:  rdata_next = fall_en_reg;
        ADDR_EDGE_CAP: rdata_next = edge_cap_reg;
        ADDR_IRQ_EN:   rdata_next = irq_en_reg;
        default:       rdata_next = rdata_reg;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      out_reg      <= '0;
      dir_reg      <= '0;
      rise_en_reg  <= '0;
      fall_en_reg  <= '0;
      irq_en_reg   <= '0;
      edge_cap_reg <= '0;
      pin_prev_reg <= '0;
      rdata_reg    <= '0;
    end else begin
      out_reg      <= out_next;
      edge_cap_reg <= edge_cap_next;
      pin_prev_reg <= pin_s;
      rdata_reg    <= rdata_next;
      if (wr) begin
        case (addr)
          ADDR_DIR:     dir_reg     <= wdata;
          ADDR_RISE_EN: rise_en_reg <= wdata;
          ADDR_FALL_EN: fall_en_reg <= wdata;
          ADDR_IRQ_EN:  irq_en_reg  <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign rdata = rdata_reg;
  assign irq   = |(edge_cap_reg & irq_en_reg);

endmodule

// File: tb/tb_gpio_bidir_port.sv
module tb_gpio_bidir_port;

  logic        clk;
  logic        rst;
  logic [2:0]  addr;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  wire  [31:0] GPIO;

  // Bench-side pin drivers: tb_oe selects which pins the bench drives.
  logic [31:0] tb_oe;
  logic [31:0] tb_val;

  int tests_run;
  int fails;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  gpio_bidir_port #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .CLOCK_50(clk),
    .Reset   (rst),
    .addr    (addr),
    .wr      (wr),
    .rd      (rd),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .GPIO    (GPIO)
  );

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_tb_drive
      assign GPIO[gi] = tb_oe[gi] ? tb_val[gi] : 1'bz;
    end
  endgenerate

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    cycle();
    wr    = 1'b0;
    $display("[TB] write addr=%0d data=%h", a, d);
  endtask

  // Drives one read and pushes its expected data onto the scoreboard.
  task automatic issue_read(input logic [2:0] a, input logic [31:0] e);
    sb.push_back(e);
    addr = a;
    rd   = 1'b1;
    cycle();
    rd   = 1'b0;
    $display("[TB] read addr=%0d data=%h", a, rdata);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    wr     = 1'b0;
    rd     = 1'b0;
    addr   = '0;
    wdata  = '0;
    tb_oe  = 32'hFFFF_FFFF;
    tb_val = 32'h5A5A_5A5A;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    tests_run++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    issue_read(3'd1, 32'h0);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL reset_dir: got %h expected %h", rdata, exp_v);
    end
    issue_read(3'd2, 32'h0);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL reset_out: got %h expected %h", rdata, exp_v);
    end
    // All pins high-Z: the bench's own pattern must come back unaltered.
    issue_read(3'd0, 32'h5A5A_5A5A);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL reset_pins_hiz: got %h expected %h", rdata, exp_v);
    end
    // Reset arriving in the middle of a DIR write discards the write.
    addr  = 3'd1;
    wdata = 32'hFFFF_FFFF;
    wr    = 1'b1;
    #5 rst = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    #2 rst = 1'b0;
    cycle();
    issue_read(3'd1, 32'h0);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL reset_mid_write_dir: got %h expected %h", rdata, exp_v);
    end
  endtask

  task automatic test_output();
    tb_oe  = 32'hFFFF_FF00;
    tb_val = 32'h1234_5600;
    write_reg(3'd1, 32'h0000_00FF);
    write_reg(3'd0, 32'h0000_00A5);
    tests_run++;
    if (GPIO[7:0] !== 8'hA5) begin
      fails++;
      $display("FAIL out_data_pins: got %h expected %h", GPIO[7:0], 8'hA5);
    end
    write_reg(3'd2, 32'h0000_0002);
    write_reg(3'd3, 32'h0000_0001);
    tests_run++;
    if (GPIO[7:0] !== 8'hA6) begin
      fails++;
      $display("FAIL out_set_clr_pins: got %h expected %h", GPIO[7:0], 8'hA6);
    end
    cycle();
    cycle();
    // Low byte is loopback; the upper pins must still be the bench's values.
    issue_read(3'd0, 32'h1234_56A6);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL out_loopback: got %h expected %h", rdata, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    addr  = 3'd2;
    wdata = 32'h0000_0010;
    wr    = 1'b1;
    cycle();
    addr  = 3'd3;
    wdata = 32'h0000_0004;
    cycle();
    addr  = 3'd2;
    wdata = 32'h0000_0001;
    cycle();
    wr    = 1'b0;
    $display("[TB] back-to-back SET/CLR/SET issued");
    tests_run++;
    if (rdata !== 32'h1234_56A6) begin
      fails++;
      $display("FAIL rdata_hold: got %h expected %h", rdata, 32'h1234_56A6);
    end
    issue_read(3'd3, 32'h0000_00B3);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL back_to_back_out: got %h expected %h", rdata, exp_v);
    end
  endtask

  task automatic test_rise_irq();
    tb_val[12] = 1'b0;
    repeat (4) cycle();
    write_reg(3'd4, 32'h0000_1000);
    write_reg(3'd7, 32'h0000_1000);
    tb_val[12] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++;
      if (irq !== (k == 2)) begin
        fails++;
        $display("FAIL rise_irq_edge%0d: got %b expected %b", k, irq, (k == 2));
      end
    end
    issue_read(3'd6, 32'h0000_1000);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL rise_capture: got %h expected %h", rdata, exp_v);
    end
    write_reg(3'd6, 32'h0000_1000);
    tests_run++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL rise_w1c_irq: got %b expected 0", irq);
    end
    issue_read(3'd6, 32'h0);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL rise_w1c_cap: got %h expected %h", rdata, exp_v);
    end
  endtask

  task automatic test_fall_only();
    write_reg(3'd1, 32'h0);
    tb_oe     = 32'hFFFF_FFFF;
    tb_val[3] = 1'b0;
    write_reg(3'd4, 32'h0);
    write_reg(3'd5, 32'h0000_0008);
    write_reg(3'd7, 32'h0);
    repeat (4) cycle();
    tb_val[3] = 1'b1;
    repeat (4) cycle();
    issue_read(3'd6, 32'h0);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL fall_ignores_rise: got %h expected %h", rdata, exp_v);
    end
    tb_val[3] = 1'b0;
    repeat (4) cycle();
    issue_read(3'd6, 32'h0000_0008);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL fall_capture: got %h expected %h", rdata, exp_v);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL fall_irq_masked: got %b expected 0", irq);
    end
  endtask

  task automatic test_set_wins();
    write_reg(3'd6, 32'hFFFF_FFFF);
    write_reg(3'd5, 32'h0);
    write_reg(3'd4, 32'h0000_0020);
    write_reg(3'd7, 32'h0000_0020);
    tb_val[5] = 1'b0;
    repeat (4) cycle();
    tb_val[5] = 1'b1;
    repeat (4) cycle();
    tb_val[5] = 1'b0;
    repeat (4) cycle();
    // New rise lands in the capture register on the same edge as the W1C.
    tb_val[5] = 1'b1;
    cycle();
    cycle();
    write_reg(3'd6, 32'h0000_0020);
    tests_run++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL set_wins_irq: got %b expected 1", irq);
    end
    issue_read(3'd6, 32'h0000_0020);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL set_wins_cap: got %h expected %h", rdata, exp_v);
    end
    write_reg(3'd6, 32'h0000_0020);
    tests_run++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL plain_w1c_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_rd_wr_same();
    tb_oe = 32'hFFFF_FFF0;
    write_reg(3'd1, 32'h0000_0001);
    sb.push_back(32'h0000_0001);
    addr  = 3'd1;
    wdata = 32'h0000_000F;
    wr    = 1'b1;
    rd    = 1'b1;
    cycle();
    wr    = 1'b0;
    rd    = 1'b0;
    $display("[TB] read+write addr=1 data=%h", rdata);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL rdwr_old_value: got %h expected %h", rdata, exp_v);
    end
    issue_read(3'd1, 32'h0000_000F);
    exp_v = sb.pop_front();
    tests_run++;
    if (rdata !== exp_v) begin
      fails++;
      $display("FAIL rdwr_new_value: got %h expected %h", rdata, exp_v);
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_output();
    test_back_to_back();
    test_rise_irq();
    test_fall_only();
    test_set_wins();
    test_rd_wr_same();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
